// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the D-PHY HS receive data lane.
// The package has no build options. RX_SOT_ERR_TOL_EN is used by hs_sync_matcher and hs_rx_word_aligner.
package mipi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT     = 2'd1,
    ACTIVE   = 2'd2,
    WAIT_EOT = 2'd3
  } rx_state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hB8;
  localparam int         BYTE_W            = 8;
  localparam int         PAIRS_PER_BYTE    = 4;
  localparam int         HIST_W            = BYTE_W + 2;

  function automatic logic [3:0] bit_count(input logic [BYTE_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < BYTE_W; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/hs_sync_matcher.sv
// Combinational compare of the shifted history against the HS sync byte at both bit offsets.
// Build option RX_SOT_ERR_TOL_EN adds the near0/near1 (one-bit-error) outputs; otherwise they are tied low.
module hs_sync_matcher
  import mipi_rx_pkg::*;
(
  input  logic [HIST_W-1:0] hist_n,
  input  logic [BYTE_W-1:0] sync_word,
  output logic              exact0,
  output logic              exact1,
  output logic              near0,
  output logic              near1
);

  assign exact0 = (hist_n[9:2] == sync_word);
  assign exact1 = (hist_n[8:1] == sync_word);

`ifdef RX_SOT_ERR_TOL_EN
  assign near0 = (bit_count(hist_n[9:2] ^ sync_word) == 4'd1);
  assign near1 = (bit_count(hist_n[8:1] ^ sync_word) == 4'd1);
`else
  assign near0 = 1'b0;
  assign near1 = 1'b0;
`endif

endmodule

// File: rtl/hs_rx_word_aligner.sv
// HS word aligner: hunts the sync byte in the bit-pair stream, locks alignment, assembles LSB-first bytes.
// Build option RX_SOT_ERR_TOL_EN accepts a one-bit-error sync and reports it on ErrSotHS.
//
// state    | meaning
// IDLE     | no burst; history and counters clear
// HUNT     | shifting pairs, looking for sync at either offset
// ACTIVE   | locked; one byte every PAIRS_PER_BYTE enabled pairs
// WAIT_EOT | sync timed out; ignore data until deff_en drops
module hs_rx_word_aligner
  import mipi_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic              RxDDRClkHS,
  input  logic              RxRst,
  input  logic              deff_en,
  input  logic              parallel_B1,
  input  logic              parallel_B2,
  output logic [BYTE_W-1:0] RxDataHS,
  output logic              RxValidHS,
  output logic              RxActiveHS,
  output logic              RxSyncHS,
  output logic              ErrSotHS,
  output logic              ErrSotSyncHS
);

  rx_state_e         state, state_n;
  logic [HIST_W-1:0] hist, hist_d, hist_shift;
  logic              align1, align1_d;
  logic [1:0]        pair_cnt, pair_cnt_d;
  logic [7:0]        timeout_cnt, timeout_d;
  logic [BYTE_W-1:0] data_d;
  logic              valid_d, sync_d, err_sync_d;
  logic              exact0, exact1, near0, near1, lock;

  assign hist_shift = {parallel_B2, parallel_B1, hist[9:2]};

  hs_sync_matcher u_matcher (
    .hist_n    (hist_shift),
    .sync_word (SYNC_WORD),
    .exact0    (exact0),
    .exact1    (exact1),
    .near0     (near0),
    .near1     (near1)
  );

  assign lock = exact0 | exact1 | near0 | near1;

  always_comb begin
    state_n    = state;
    hist_d     = hist;
    align1_d   = align1;
    pair_cnt_d = pair_cnt;
    timeout_d  = timeout_cnt;
    data_d     = RxDataHS;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    err_sync_d = 1'b0;
    case (state)
      IDLE, HUNT: begin
        if (!deff_en) begin
          state_n    = IDLE;
          hist_d     = '0;
          pair_cnt_d = '0;
          timeout_d  = '0;
        end else begin
          hist_d    = hist_shift;
          timeout_d = timeout_cnt + 8'd1;
          state_n   = HUNT;
          if (lock) begin
            state_n    = ACTIVE;
            // priority: exact0, exact1, near0, near1
            align1_d   = !exact0 && (exact1 || !near0);
            pair_cnt_d = '0;
            sync_d     = 1'b1;
          end else if (timeout_d == 8'(SYNC_TIMEOUT)) begin
            state_n    = WAIT_EOT;
            err_sync_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!deff_en) begin
          state_n    = IDLE;
          hist_d     = '0;
          pair_cnt_d = '0;
          timeout_d  = '0;
        end else begin
          hist_d     = hist_shift;
          pair_cnt_d = pair_cnt + 2'd1;
          if (pair_cnt == 2'(PAIRS_PER_BYTE - 1)) begin
            data_d  = align1 ? hist_shift[8:1] : hist_shift[9:2];
            valid_d = 1'b1;
          end
        end
      end
      WAIT_EOT: begin
        if (!deff_en) begin
          state_n    = IDLE;
          hist_d     = '0;
          pair_cnt_d = '0;
          timeout_d  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge RxDDRClkHS or negedge RxRst) begin
    if (!RxRst) begin
      state        <= IDLE;
      hist         <= '0;
      align1       <= 1'b0;
      pair_cnt     <= '0;
      timeout_cnt  <= '0;
      RxDataHS     <= '0;
      RxValidHS    <= 1'b0;
      RxSyncHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
    end else begin
      state        <= state_n;
      hist         <= hist_d;
      align1       <= align1_d;
      pair_cnt     <= pair_cnt_d;
      timeout_cnt  <= timeout_d;
      RxDataHS     <= data_d;
      RxValidHS    <= valid_d;
      RxSyncHS     <= sync_d;
      ErrSotSyncHS <= err_sync_d;
    end
  end

  assign RxActiveHS = (state == ACTIVE);

`ifdef RX_SOT_ERR_TOL_EN
  logic err_sot_q;
  always_ff @(posedge RxDDRClkHS or negedge RxRst) begin
    if (!RxRst) err_sot_q <= 1'b0;
    else        err_sot_q <= sync_d && !exact0 && !exact1;
  end
  assign ErrSotHS = err_sot_q;
`else
  assign ErrSotHS = 1'b0;
`endif

endmodule

// File: tb/tb_hs_rx_word_aligner.sv
// Directed bench for hs_rx_word_aligner; byte scoreboard drained by a negedge monitor.
`timescale 1ns/1ps
module tb_hs_rx_word_aligner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       deff_en, b1, b2;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_sync, err_sot, err_sot_sync;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0, sync_cnt = 0, errsync_cnt = 0, errsot_cnt = 0;
  logic [7:0] exp_q[$];
  logic       pend;
  bit         have_pend;

  always #5 clk = ~clk;

  hs_rx_word_aligner dut (
    .RxDDRClkHS   (clk),
    .RxRst        (rst_n),
    .deff_en      (deff_en),
    .parallel_B1  (b1),
    .parallel_B2  (b2),
    .RxDataHS     (rx_data),
    .RxValidHS    (rx_valid),
    .RxActiveHS   (rx_active),
    .RxSyncHS     (rx_sync),
    .ErrSotHS     (err_sot),
    .ErrSotSyncHS (err_sot_sync)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_sync)      sync_cnt++;
      if (err_sot_sync) errsync_cnt++;
      if (err_sot)      errsot_cnt++;
      if (rx_valid) begin
        valid_cnt++;
        chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic pair(input logic p1, input logic p2);
    @(negedge clk);
    deff_en = 1'b1; b1 = p1; b2 = p2;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    deff_en = 1'b0; b1 = 1'b0; b2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tx_bit(input logic b);
    if (!have_pend) begin
      pend = b; have_pend = 1'b1;
    end else begin
      pair(pend, b); have_pend = 1'b0;
    end
  endtask

  task automatic sync0();
    logic [7:0] sw;
    sw = 8'hB8;
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pair(sw[2*k], sw[2*k+1]);
      chk("sync_pulse", 32'(rx_sync), 32'(k == 3));
    end
    chk("sync_active", 32'(rx_active), 32'd1);
    chk("sync_errsot", 32'(err_sot), 32'd0);
  endtask

  task automatic send_byte0(input logic [7:0] b);
    exp_q.push_back(b);
    for (int k = 0; k < 4; k++) begin
      pair(b[2*k], b[2*k+1]);
      chk("valid_timing", 32'(rx_valid), 32'(k == 3));
    end
    chk("data_a0", 32'(rx_data), 32'(b));
  endtask

  initial begin
    logic [7:0] sw, db, nw;
    int sync_before;
    rst_n = 1'b0; deff_en = 1'b1; b1 = 1'b0; b2 = 1'b0;
    have_pend = 1'b0; pend = 1'b0;

    // reset held with live data
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b1 = 1'($urandom_range(0, 1)); b2 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("reset_outs", {19'd0, rx_data, rx_valid, rx_active, rx_sync, err_sot, err_sot_sync}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; b1 = 1'b0; b2 = 1'b0;

    // align0 lock and two bytes
    sync0();
    send_byte0(8'h5A);
    send_byte0(8'hC3);
    idle();
    chk("eot_active", 32'(rx_active), 32'd0);
    chk("eot_data_hold", 32'(rx_data), 32'hC3);
    idle();

    // align1: 5-bit zero leader shifts sync to end on B1
    sw = 8'hB8; db = 8'hA5;
    have_pend = 1'b0;
    exp_q.push_back(db);
    for (int i = 0; i < 5; i++) tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(sw[i]);
    tx_bit(db[0]);
    chk("a1_sync", 32'(rx_sync), 32'd1);
    chk("a1_active", 32'(rx_active), 32'd1);
    for (int i = 1; i < 8; i++) tx_bit(db[i]);
    tx_bit(1'b0);
    chk("a1_valid", 32'(rx_valid), 32'd1);
    chk("a1_data", 32'(rx_data), 32'hA5);
    idle(); idle();

    // reset mid-burst, then a fresh burst with deff_en already high
    sync0();
    pair(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outs", {19'd0, rx_data, rx_valid, rx_active, rx_sync, err_sot, err_sot_sync}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; b1 = 1'b0; b2 = 1'b0;
    sync0();
    send_byte0(8'h96);
    idle(); idle();

    // sync timeout
    sync_before = sync_cnt;
    for (int i = 1; i <= 40; i++) begin
      pair(1'b0, 1'b0);
      chk("timeout_err", 32'(err_sot_sync), 32'(i == 32));
    end
    chk("timeout_inactive", 32'(rx_active), 32'd0);
    idle();
    chk("timeout_nolock", 32'(sync_cnt), 32'(sync_before));
    sync0();
    send_byte0(8'h3C);

    // partial byte at EoT
    pair(1'b1, 1'b1);
    pair(1'b1, 1'b1);
    idle();
    chk("partial_active", 32'(rx_active), 32'd0);
    chk("partial_valid", 32'(rx_valid), 32'd0);
    chk("partial_hold", 32'(rx_data), 32'h3C);
    idle();

    // one-bit-error sync 8'hB9
    nw = 8'hB9;
    sync_before = sync_cnt;
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) pair(nw[2*k], nw[2*k+1]);
`ifdef RX_SOT_ERR_TOL_EN
    chk("tol_sync", 32'(rx_sync), 32'd1);
    chk("tol_errsot", 32'(err_sot), 32'd1);
    chk("tol_active", 32'(rx_active), 32'd1);
`else
    chk("strict_nolock", 32'(rx_sync), 32'd0);
    for (int i = 9; i <= 34; i++) begin
      pair(1'b0, 1'b0);
      chk("strict_timeout", 32'(err_sot_sync), 32'(i == 32));
    end
`endif
    idle(); idle();

`ifdef RX_SOT_ERR_TOL_EN
    chk("cnt_sync", 32'(sync_cnt), 32'd6);
    chk("cnt_errsync", 32'(errsync_cnt), 32'd1);
    chk("cnt_errsot", 32'(errsot_cnt), 32'd1);
`else
    chk("cnt_sync", 32'(sync_cnt), 32'd5);
    chk("cnt_errsync", 32'(errsync_cnt), 32'd2);
    chk("cnt_errsot", 32'(errsot_cnt), 32'd0);
`endif
    chk("cnt_valid", 32'(valid_cnt), 32'd5);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hs_rx_word_aligner.md
Name: hs_rx_word_aligner

Overview:
- Sits directly downstream of the HS dual-edge sampler in the D-PHY receiver data lane.
- Consumes one bit pair per RxDDRClkHS cycle (parallel_B1 then parallel_B2), hunts for the HS leader/sync byte and locks byte alignment at either bit offset.
- Assembles LSB-first bytes and presents them on PPI-style outputs with valid, sync and active flags, plus SoT sync error reporting.

Parameters:
- SYNC_WORD, 8'hB8, HS sync byte; wire order LSB first: 0,0,0,1,1,1,0,1.
- SYNC_TIMEOUT, 32, enabled pair-cycles allowed in HUNT before a sync error is declared; range 2..255.

Ports:
- RxDDRClkHS  in  1  HS DDR receive clock; single clock domain, all state on its rising edge.
- RxRst  in  1  asynchronous, active-low reset.
- deff_en  in  1  pair-valid/HS-burst enable, same signal that enables the upstream sampler.
- parallel_B1  in  1  earlier bit of the current pair.
- parallel_B2  in  1  later bit of the current pair.
- RxDataHS  out  8  assembled byte, bit0 = first received.
- RxValidHS  out  1  one-cycle pulse, RxDataHS is new.
- RxActiveHS  out  1  high from sync lock until end of burst.
- RxSyncHS  out  1  one-cycle pulse on sync lock.
- ErrSotHS  out  1  one-cycle pulse; sync accepted with a 1-bit error (optional feature).
- ErrSotSyncHS  out  1  one-cycle pulse; sync not found within SYNC_TIMEOUT.

Behaviour:
- Reset (RxRst=0, async): all outputs 0, RxDataHS=8'h00, state IDLE, history and counters cleared.
- History hist[9:0]. On an enabled cycle: hist_n = {B2, B1, hist[9:2]}. Disabled cycles do not shift.
- Sync compare runs on hist_n:
  - align0 match: hist_n[9:2]==SYNC_WORD (sync ends on B2).
  - align1 match: hist_n[8:1]==SYNC_WORD (sync ends on B1).
  - For SYNC_WORD=8'hB8 both cannot match at once; priority is align0 anyway.
- States:
  - IDLE: deff_en=1 -> HUNT; the same cycle's pair is shifted and compared.
  - HUNT: a match stores align and clears pair_cnt -> ACTIVE; RxSyncHS and RxActiveHS go high on the next edge. deff_en=0 -> IDLE, no error. timeout_cnt reaching SYNC_TIMEOUT with no match -> ErrSotSyncHS pulse, go to WAIT_EOT.
  - ACTIVE: each enabled cycle increments pair_cnt mod 4. When pair_cnt==3, register RxDataHS = align0 ? hist_n[9:2] : hist_n[8:1] and pulse RxValidHS (1-cycle latency from the last bit sampled). For align1, the B2 of that pair is bit0 of the next byte. deff_en=0 -> IDLE; RxActiveHS falls on that edge and any partial byte is discarded without a RxValidHS.
  - WAIT_EOT: ignore data until deff_en=0, then go to IDLE.
- RxDataHS holds its value between pulses and is not cleared at end of transmission.
- On IDLE entry, hist and counters are cleared so stale bits cannot form a false sync in the next burst.
- A reset asserted mid-burst drops everything immediately. After release, deff_en already high is treated as a new burst (IDLE->HUNT).
- Throughput: one byte per 4 enabled cycles. Disabled cycles inside ACTIVE are burst end, not gaps.

Optional Feature:
- Macro: RX_SOT_ERR_TOL_EN.
- Defined: if no exact match at either alignment, a Hamming distance of 1 is also accepted (align0 checked first). Lock proceeds normally and ErrSotHS pulses together with RxSyncHS. Exact matches are never flagged.
- Undefined: exact match only, ErrSotHS tied to 0.

Decomposition:
- Package mipi_rx_pkg: state enum (IDLE, HUNT, ACTIVE, WAIT_EOT), SYNC_WORD default 8'hB8, byte-width and pairs-per-byte constants.
- Sub-module hs_sync_matcher: combinational. Takes hist_n and SYNC_WORD; outputs exact0, exact1, near0, near1. The near outputs are generated only under RX_SOT_ERR_TOL_EN.

Test Plan:
- Reset: hold RxRst=0 with random pairs and deff_en=1 -> all outputs 0 throughout; release into 4 zero pairs, then sync bits 00/01/11/01 -> align0 lock, RxSyncHS pulse, RxActiveHS=1.
- Align0 data: after sync send bytes 8'h5A, 8'hC3 LSB-first -> RxValidHS pulses 4 cycles apart, RxDataHS 8'h5A then 8'hC3, each 1 cycle after its last pair.
- Align1: leader of 5 zero bits, then sync, then byte 8'hA5 -> lock with align1, RxDataHS=8'hA5.
- Timeout: 40 enabled pairs of 00 -> ErrSotSyncHS pulses at pair 32; no RxSyncHS; after deff_en=0, a new burst locks correctly.
- EoT and partial byte: deff_en drops 2 pairs into a byte -> RxActiveHS falls, no RxValidHS, RxDataHS keeps the last full byte.
- Optional: with RX_SOT_ERR_TOL_EN, sync 8'hB9 -> lock, RxSyncHS and ErrSotHS pulse together. Without the macro -> no lock, ErrSotSyncHS after 32 pairs.
